// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
//   Sequencer for the TLB management instructions (TLBSRCH / TLBRD / TLBWR /
//   TLBFILL). Commit hands over one op at a time. The controller runs a single
//   variable-latency access on the TLB array, then strobes the CSR updates
//   (TLBELO0/1, TLBEHI, TLBIDX) during one COMMIT cycle and returns to IDLE.
//   Only one op is ever in flight; commit stalls while op_ready is low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid/op_ready   op handshake; accepted when both are high
//   op_code             0 SRCH, 1 RD, 2 WR, 3 FILL, 4-7 illegal
//   csr_idx             TLBIDX.Index, sampled at accept
//   tlb_req             array access request, held until tlb_ack
//   tlb_we / tlb_srch   access kind (write for WR/FILL, search for SRCH)
//   tlb_idx             entry index for RD/WR/FILL
//   tlb_ack             array done; result inputs valid in this cycle only
//   tlb_hit/_hit_idx    search result
//   tlb_rd_e            E bit of the entry read
//   TLBRD_en            load TLBELO0/1, TLBEHI, ASID, PS from array read data
//   rd_clear            clear TLBELO0/1, TLBEHI, ASID, PS
//   idx_index_we/wdata  TLBIDX.Index write strobe and value
//   idx_ne_we/idx_ne    TLBIDX.NE write strobe and value
//   done                one-cycle completion pulse
// -----------------------------------------------------------------------------
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [IDX_W-1:0] csr_idx,
    output logic             tlb_req,
    output logic             tlb_we,
    output logic             tlb_srch,
    output logic [IDX_W-1:0] tlb_idx,
    input  logic             tlb_ack,
    input  logic             tlb_hit,
    input  logic [IDX_W-1:0] tlb_hit_idx,
    input  logic             tlb_rd_e,
    output logic             TLBRD_en,
    output logic             rd_clear,
    output logic             idx_index_we,
    output logic [IDX_W-1:0] idx_wdata,
    output logic             idx_ne_we,
    output logic             idx_ne,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;

    localparam logic [IDX_W-1:0] FILL_LAST   = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [IDX_W:0]   ENTRIES_EXT = (IDX_W + 1)'(TLB_ENTRIES);

    state_e             state_q,        state_d;
    logic [2:0]         op_q,           op_d;
    logic               skip_q,         skip_d;
    logic [IDX_W-1:0]   fill_cnt_q,     fill_cnt_d;
    logic               tlb_req_q,      tlb_req_d;
    logic               tlb_we_q,       tlb_we_d;
    logic               tlb_srch_q,     tlb_srch_d;
    logic [IDX_W-1:0]   tlb_idx_q,      tlb_idx_d;
    logic               rd_en_q,        rd_en_d;
    logic               rd_clear_q,     rd_clear_d;
    logic               index_we_q,     index_we_d;
    logic [IDX_W-1:0]   wdata_q,        wdata_d;
    logic               ne_we_q,        ne_we_d;
    logic               ne_q,           ne_d;
    logic               done_q,         done_d;

    logic               rd_idx_bad;
    logic               access_end;
    logic               res_hit;
    logic               res_e;

    // An RD whose index points past the array has nothing to read; it is
    // handled like a read of an entry with E=0.
    assign rd_idx_bad = ({1'b0, csr_idx} >= ENTRIES_EXT);

    // A skipped op (illegal code or out-of-range RD) spends its ACCESS cycle
    // with tlb_req low and finishes unconditionally, so every op has the same
    // two-cycle minimum from accept to done. Array results are ignored then.
    assign access_end = skip_q | tlb_ack;
    assign res_hit    = tlb_hit  & ~skip_q;
    assign res_e      = tlb_rd_e & ~skip_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        skip_d     = skip_q;
        tlb_req_d  = tlb_req_q;
        tlb_we_d   = tlb_we_q;
        tlb_srch_d = tlb_srch_q;
        tlb_idx_d  = tlb_idx_q;
        // CSR strobes and done are single-cycle: default low every cycle.
        rd_en_d    = 1'b0;
        rd_clear_d = 1'b0;
        index_we_d = 1'b0;
        wdata_d    = '0;
        ne_we_d    = 1'b0;
        ne_d       = 1'b0;
        done_d     = 1'b0;

        // Free-running allocation counter for TLBFILL.
        fill_cnt_d = (fill_cnt_q == FILL_LAST) ? '0 : fill_cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    state_d = ST_ACCESS;
                    op_d    = op_code;
                    skip_d  = 1'b0;
                    case (op_code)
                        OP_SRCH: begin
                            tlb_req_d  = 1'b1;
                            tlb_srch_d = 1'b1;
                            tlb_idx_d  = '0;
                        end
                        OP_RD: begin
                            tlb_req_d = ~rd_idx_bad;
                            skip_d    = rd_idx_bad;
                            tlb_idx_d = rd_idx_bad ? '0 : csr_idx;
                        end
                        OP_WR: begin
                            tlb_req_d = 1'b1;
                            tlb_we_d  = 1'b1;
                            tlb_idx_d = csr_idx;
                        end
                        OP_FILL: begin
                            tlb_req_d = 1'b1;
                            tlb_we_d  = 1'b1;
                            tlb_idx_d = fill_cnt_q;
                        end
                        default: begin
                            skip_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_ACCESS: begin
                if (access_end) begin
                    state_d    = ST_COMMIT;
                    skip_d     = 1'b0;
                    tlb_req_d  = 1'b0;
                    tlb_we_d   = 1'b0;
                    tlb_srch_d = 1'b0;
                    tlb_idx_d  = '0;
                    done_d     = 1'b1;
                    case (op_q)
                        OP_SRCH: begin
                            ne_we_d = 1'b1;
                            if (res_hit) begin
                                index_we_d = 1'b1;
                                wdata_d    = tlb_hit_idx;
                                ne_d       = 1'b0;
                            end else begin
                                ne_d = 1'b1;
                            end
                        end
                        OP_RD: begin
                            ne_we_d = 1'b1;
                            if (res_e) begin
                                rd_en_d = 1'b1;
                                ne_d    = 1'b0;
                            end else begin
                                rd_clear_d = 1'b1;
                                ne_d       = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            skip_q     <= 1'b0;
            fill_cnt_q <= '0;
            tlb_req_q  <= 1'b0;
            tlb_we_q   <= 1'b0;
            tlb_srch_q <= 1'b0;
            tlb_idx_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_clear_q <= 1'b0;
            index_we_q <= 1'b0;
            wdata_q    <= '0;
            ne_we_q    <= 1'b0;
            ne_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            skip_q     <= skip_d;
            fill_cnt_q <= fill_cnt_d;
            tlb_req_q  <= tlb_req_d;
            tlb_we_q   <= tlb_we_d;
            tlb_srch_q <= tlb_srch_d;
            tlb_idx_q  <= tlb_idx_d;
            rd_en_q    <= rd_en_d;
            rd_clear_q <= rd_clear_d;
            index_we_q <= index_we_d;
            wdata_q    <= wdata_d;
            ne_we_q    <= ne_we_d;
            ne_q       <= ne_d;
            done_q     <= done_d;
        end
    end

    assign op_ready     = (state_q == ST_IDLE);
    assign tlb_req      = tlb_req_q;
    assign tlb_we       = tlb_we_q;
    assign tlb_srch     = tlb_srch_q;
    assign tlb_idx      = tlb_idx_q;
    assign TLBRD_en     = rd_en_q;
    assign rd_clear     = rd_clear_q;
    assign idx_index_we = index_we_q;
    assign idx_wdata    = wdata_q;
    assign idx_ne_we    = ne_we_q;
    assign idx_ne       = ne_q;
    assign done         = done_q;

endmodule
